// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and sizing constants for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_REL  = 2'd2
  } arb_state_e;
  localparam int MAX_REQ = 4;
  localparam int PTR_W   = $clog2(MAX_REQ);
  localparam int TMO_W   = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first active port at or after ptr_i
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PTR_W-1:0]   idx_o
);
  // scan from farthest to nearest so the port closest to ptr_i overwrites the rest
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        pick_o = NUM_REQ'(1) << ((int'(ptr_i) + k) % NUM_REQ);
        idx_o  = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the memory access controller; ARB_TIMEOUT_EN adds a BUSY watchdog
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rdata,
  output logic [NUM_REQ-1:0]    err,
  output logic                  mac_mr,
  output logic                  mac_mw,
  output logic [AW-1:0]         mac_addr,
  output logic [DW-1:0]         mac_wdata,
  input  logic                  mac_ack_n,
  input  logic [DW-1:0]         mac_rdata
);
  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q, done_q, pick;
  logic [PTR_W-1:0]   rr_ptr_q, idx_q, pick_idx;
  logic               mac_mr_q, mac_mw_q;
  logic [AW-1:0]      mac_addr_q;
  logic [DW-1:0]      mac_wdata_q, rdata_q;
`ifdef ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] err_q;
  logic [TMO_W-1:0]   cnt_q;
  assign err = err_q;
`else
  assign err = '0;
`endif
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req_rd | req_wr),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );
  // transaction FSM: grant and bus mux registered in IDLE, held through BUSY, released in REL
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      mac_mr_q    <= 1'b0;
      mac_mw_q    <= 1'b0;
      mac_addr_q  <= '0;
      mac_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE:
          if (|(req_rd | req_wr)) begin
            gnt_q       <= pick;
            idx_q       <= pick_idx;
            mac_addr_q  <= req_addr[pick_idx*AW +: AW];
            mac_wdata_q <= req_wdata[pick_idx*DW +: DW];
            mac_mw_q    <= req_wr[pick_idx];
            mac_mr_q    <= req_rd[pick_idx] & ~req_wr[pick_idx];
            state_q     <= ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        ARB_BUSY:
          if (!mac_ack_n) begin
            if (mac_mr_q) rdata_q <= mac_rdata;
            done_q   <= gnt_q;
            mac_mr_q <= 1'b0;
            mac_mw_q <= 1'b0;
            state_q  <= ARB_REL;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == TMO_W'(TMO_CYC - 1)) begin
            err_q    <= gnt_q;
            mac_mr_q <= 1'b0;
            mac_mw_q <= 1'b0;
            state_q  <= ARB_REL;
          end else cnt_q <= cnt_q + 1'b1;
`endif
        ARB_REL: begin
          done_q   <= '0;
          gnt_q    <= '0;
          rr_ptr_q <= (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q  <= ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
          err_q    <= '0;
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mac_mr    = mac_mr_q;
  assign mac_mw    = mac_mw_q;
  assign mac_addr  = mac_addr_q;
  assign mac_wdata = mac_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter (2 ports, TMO_CYC=10)
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_rd = '0, req_wr = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  gnt, done, err;
  logic [31:0] rdata, mac_addr, mac_wdata;
  logic        mac_mr, mac_mw;
  logic        mac_ack_n = 1'b1;
  logic [31:0] mac_rdata = '0;
  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.NUM_REQ(2), .AW(32), .DW(32), .TMO_CYC(10)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .mac_mr(mac_mr), .mac_mw(mac_mw),
    .mac_addr(mac_addr), .mac_wdata(mac_wdata), .mac_ack_n(mac_ack_n),
    .mac_rdata(mac_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_rd = '0;
    req_wr = '0;
    mac_ack_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // one granted read with an immediate ACK; ends on the first IDLE cycle after REL
  task automatic txn(input string tag, input logic [1:0] eg, input logic [31:0] ea);
    @(negedge clk);
    check({tag, " gnt"}, gnt, eg);
    check({tag, " addr"}, mac_addr, ea);
    check({tag, " mr"}, mac_mr, 1);
    mac_ack_n = 1'b0;
    mac_rdata = ea ^ 32'hA5A5_0000;
    @(negedge clk);
    mac_ack_n = 1'b1;
    check({tag, " done"}, done, eg);
    check({tag, " rdata"}, rdata, ea ^ 32'hA5A5_0000);
    @(negedge clk);
    check({tag, " rel gnt"}, gnt, 0);
    check({tag, " rel done"}, done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst gnt", gnt, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst mr", mac_mr, 0);
    check("rst mw", mac_mw, 0);
    check("rst addr", mac_addr, 0);
    check("rst wdata", mac_wdata, 0);
    check("rst rdata", rdata, 0);
    reset = 1'b0;

    // single read on port 0, ACK after 3 cycles
    req_rd = 2'b01;
    req_addr[31:0] = 32'h100;
    @(negedge clk);
    check("rd gnt", gnt, 2'b01);
    check("rd mr", mac_mr, 1);
    check("rd mw", mac_mw, 0);
    check("rd addr", mac_addr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rd wait done", done, 0);
      check("rd wait gnt", gnt, 2'b01);
    end
    mac_ack_n = 1'b0;
    mac_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mac_ack_n = 1'b1;
    mac_rdata = 32'h0;
    check("rd done", done, 2'b01);
    check("rd rdata", rdata, 32'hDEAD_BEEF);
    check("rd mr drop", mac_mr, 0);
    req_rd = 2'b00;
    @(negedge clk);
    check("rd idle done", done, 0);
    check("rd idle gnt", gnt, 0);
    check("rd rdata hold", rdata, 32'hDEAD_BEEF);

    // both ports from reset: round-robin 01,10,01
    do_reset();
    req_rd = 2'b11;
    req_addr = {32'h200, 32'h100};
    txn("rr1", 2'b01, 32'h100);
    txn("rr2", 2'b10, 32'h200);
    txn("rr3", 2'b01, 32'h100);
    req_rd = 2'b00;

    // port 1 read+write together: write wins
    do_reset();
    req_rd = 2'b10;
    req_wr = 2'b10;
    req_addr = {32'h300, 32'h0};
    req_wdata = {32'h55, 32'h0};
    @(negedge clk);
    check("wr gnt", gnt, 2'b10);
    check("wr mw", mac_mw, 1);
    check("wr mr", mac_mr, 0);
    check("wr wdata", mac_wdata, 32'h55);
    check("wr addr", mac_addr, 32'h300);
    mac_ack_n = 1'b0;
    @(negedge clk);
    mac_ack_n = 1'b1;
    check("wr done", done, 2'b10);
    check("wr mw drop", mac_mw, 0);
    req_rd = 2'b00;
    req_wr = 2'b00;
    @(negedge clk);
    check("wr idle done", done, 0);

    // ACK_N held low for 3 cycles: a single done, no stray grant
    do_reset();
    req_rd = 2'b01;
    req_addr = {32'h0, 32'h400};
    @(negedge clk);
    check("ackl gnt", gnt, 2'b01);
    mac_ack_n = 1'b0;
    @(negedge clk);
    check("ackl done", done, 2'b01);
    req_rd = 2'b00;
    @(negedge clk);
    check("ackl rel done", done, 0);
    check("ackl rel gnt", gnt, 0);
    @(negedge clk);
    check("ackl idle done", done, 0);
    check("ackl idle gnt", gnt, 0);
    mac_ack_n = 1'b1;

    // reset asserted while BUSY
    req_rd = 2'b01;
    @(negedge clk);
    check("rstb gnt", gnt, 2'b01);
    reset = 1'b1;
    req_rd = 2'b00;
    mac_ack_n = 1'b0;
    @(negedge clk);
    check("rstb gnt0", gnt, 0);
    check("rstb mr", mac_mr, 0);
    check("rstb done", done, 0);
    reset = 1'b0;
    mac_ack_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstb no done", done, 0);
    end

`ifdef ARB_TIMEOUT_EN
    // watchdog: no ACK, err after 10 cycles, then port 1 served
    do_reset();
    req_rd = 2'b11;
    req_addr = {32'h600, 32'h500};
    @(negedge clk);
    check("tmo gnt", gnt, 2'b01);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check("tmo no err", err, 0);
    end
    @(negedge clk);
    check("tmo err", err, 2'b01);
    check("tmo done", done, 0);
    check("tmo mr", mac_mr, 0);
    @(negedge clk);
    check("tmo err clr", err, 0);
    check("tmo rel gnt", gnt, 0);
    @(negedge clk);
    check("tmo next gnt", gnt, 2'b10);
    check("tmo next addr", mac_addr, 32'h600);
    req_rd = 2'b00;
    mac_ack_n = 1'b0;
    repeat (3) @(negedge clk);
    mac_ack_n = 1'b1;
`else
    check("no tmo err", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
